// File: rtl/game_pkg.sv
// Shared definitions for the runner's game logic.
// Holds the vertical-physics state encoding, the default accumulator and velocity
// widths, and the matching velocity and height-accumulator typedefs.
package game_pkg;

    localparam int unsigned ACC_W        = 14;
    localparam int unsigned VEL_W        = 11;
    localparam int unsigned HEIGHT_SHIFT = 4;

    typedef enum logic [1:0] {
        StGround = 2'd0,
        StAir    = 2'd1,
        StDuck   = 2'd2
    } state_t;

    typedef logic signed [VEL_W-1:0] velocity_t;
    typedef logic        [ACC_W-1:0] height_acc_t;

endpackage

// File: rtl/vertical_integrator.sv
// Combinational single-frame step of the jump integrator.
// Ports:
//   acc      current height accumulator (unsigned)
//   vel      velocity to apply this frame (signed, already fast-fall adjusted)
//   grav     latched per-frame velocity decrement
//   acc_next accumulator after the step (0 on landing, clamped at full scale)
//   vel_next velocity after the step (0 on landing, saturates at most negative value)
//   land     the step reaches or passes the ground
module vertical_integrator #(
    parameter int unsigned ACC_W  = 14,
    parameter int unsigned VEL_W  = 11,
    parameter int unsigned GRAV_W = 4
) (
    input  logic        [ACC_W-1:0]  acc,
    input  logic signed [VEL_W-1:0]  vel,
    input  logic        [GRAV_W-1:0] grav,
    output logic        [ACC_W-1:0]  acc_next,
    output logic signed [VEL_W-1:0]  vel_next,
    output logic                     land
);

    localparam int unsigned SUM_W = ACC_W + 2;
    localparam logic signed [VEL_W-1:0] VEL_MIN = {1'b1, {(VEL_W-1){1'b0}}};

    logic signed [SUM_W-1:0] sum;
    logic signed [VEL_W:0]   vel_dec;

    always_comb begin
        sum     = $signed({2'b00, acc}) + $signed({{(SUM_W-VEL_W){vel[VEL_W-1]}}, vel});
        vel_dec = $signed({vel[VEL_W-1], vel})
                - $signed({{(VEL_W+1-GRAV_W){1'b0}}, grav});

        land     = sum[SUM_W-1] || (sum == '0);
        acc_next = '0;
        vel_next = '0;

        if (!land) begin
            // Positive overflow of the accumulator clamps instead of wrapping.
            if (|sum[SUM_W-2:ACC_W]) begin
                acc_next = '1;
            end else begin
                acc_next = sum[ACC_W-1:0];
            end
            // Two top bits disagree only on negative overflow.
            if (vel_dec[VEL_W] != vel_dec[VEL_W-1]) begin
                vel_next = VEL_MIN;
            end else begin
                vel_next = vel_dec[VEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/player_vertical.sv
// Per-frame vertical physics for the runner: jump integration, duck/roll, landing.
// Ports:
//   clk_in, rst_in      clock and synchronous active-high reset
//   frame_tick_in       one-cycle pulse per frame; physics steps only on it
//   game_active_in      low forces the player to the ground and ignores ticks
//   jump_in, duck_in    one-cycle requests, held pending until the next tick
//   gravity_in, duck_limit_in, vertical_jump_in   current speed parameters
//   height_out          accumulator >> HEIGHT_SHIFT, saturated to 1023
//   airborne_out, ducking_out   pose of the player
//   landed_out          one-cycle pulse after the landing tick
module player_vertical #(
    parameter int unsigned HEIGHT_SHIFT = game_pkg::HEIGHT_SHIFT,
    parameter int unsigned ACC_W        = game_pkg::ACC_W,
    parameter int unsigned VEL_W        = game_pkg::VEL_W
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       frame_tick_in,
    input  logic       game_active_in,
    input  logic       jump_in,
    input  logic       duck_in,
    input  logic [3:0] gravity_in,
    input  logic [7:0] duck_limit_in,
    input  logic [9:0] vertical_jump_in,
    output logic [9:0] height_out,
    output logic       airborne_out,
    output logic       ducking_out,
    output logic       landed_out
);

    import game_pkg::*;

    state_t                  state_q, state_d;
    logic        [ACC_W-1:0] acc_q, acc_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic        [3:0]       g_l_q, g_l_d;
    logic        [9:0]       vj_l_q, vj_l_d;
    logic        [7:0]       cnt_q, cnt_d;
    logic                    jump_pend_q, jump_pend_d;
    logic                    duck_pend_q, duck_pend_d;
    logic                    land_duck_q, land_duck_d;
    logic                    landed_q, landed_d;

    logic                    jump_req;
    logic                    duck_req;
    logic        [7:0]       duck_load;
    logic signed [VEL_W-1:0] takeoff_vel;
    logic signed [VEL_W-1:0] vj_ext;
    logic signed [VEL_W-1:0] vel_eff;
    logic        [ACC_W-1:0] int_acc;
    logic signed [VEL_W-1:0] int_vel;
    logic                    int_land;
    logic        [ACC_W-1:0] acc_sh;

    // A request in the same cycle as the tick counts for that tick.
    assign jump_req  = jump_pend_q | jump_in;
    assign duck_req  = duck_pend_q | duck_in;
    assign duck_load = (duck_limit_in == 8'd0) ? 8'd1 : duck_limit_in;

    assign takeoff_vel = $signed({{(VEL_W-10){1'b0}}, vertical_jump_in})
                       - $signed({{(VEL_W-4){1'b0}}, gravity_in});
    assign vj_ext      = $signed({{(VEL_W-10){1'b0}}, vj_l_q});

    // Fast-fall: a duck while airborne replaces the velocity with the takeoff speed downward.
    assign vel_eff = duck_req ? -vj_ext : vel_q;

    vertical_integrator #(
        .ACC_W  (ACC_W),
        .VEL_W  (VEL_W),
        .GRAV_W (4)
    ) u_integrator (
        .acc      (acc_q),
        .vel      (vel_eff),
        .grav     (g_l_q),
        .acc_next (int_acc),
        .vel_next (int_vel),
        .land     (int_land)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        vel_d       = vel_q;
        g_l_d       = g_l_q;
        vj_l_d      = vj_l_q;
        cnt_d       = cnt_q;
        jump_pend_d = jump_req;
        duck_pend_d = duck_req;
        land_duck_d = land_duck_q;
        landed_d    = 1'b0;

        if (!game_active_in) begin
            state_d     = StGround;
            acc_d       = '0;
            vel_d       = '0;
            cnt_d       = '0;
            jump_pend_d = 1'b0;
            duck_pend_d = 1'b0;
            land_duck_d = 1'b0;
        end else if (frame_tick_in) begin
            jump_pend_d = 1'b0;
            duck_pend_d = 1'b0;
            case (state_q)
                StGround, StDuck: begin
                    if (jump_req) begin
                        // Trajectory parameters are frozen for the whole jump.
                        g_l_d       = gravity_in;
                        vj_l_d      = vertical_jump_in;
                        vel_d       = takeoff_vel;
                        acc_d       = {{(ACC_W-10){1'b0}}, vertical_jump_in};
                        land_duck_d = 1'b0;
                        state_d     = StAir;
                    end else if (duck_req) begin
                        cnt_d   = duck_load;
                        state_d = StDuck;
                    end else if (state_q == StDuck) begin
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q <= 8'd1) begin
                            state_d = StGround;
                        end
                    end
                end
                StAir: begin
                    if (int_land) begin
                        acc_d       = '0;
                        vel_d       = '0;
                        landed_d    = 1'b1;
                        land_duck_d = 1'b0;
                        if (land_duck_q || duck_req) begin
                            cnt_d   = duck_load;
                            state_d = StDuck;
                        end else begin
                            state_d = StGround;
                        end
                    end else begin
                        acc_d       = int_acc;
                        vel_d       = int_vel;
                        land_duck_d = land_duck_q | duck_req;
                    end
                end
                default: begin
                    state_d = StGround;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StGround;
            acc_q       <= '0;
            vel_q       <= '0;
            g_l_q       <= '0;
            vj_l_q      <= '0;
            cnt_q       <= '0;
            jump_pend_q <= 1'b0;
            duck_pend_q <= 1'b0;
            land_duck_q <= 1'b0;
            landed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            vel_q       <= vel_d;
            g_l_q       <= g_l_d;
            vj_l_q      <= vj_l_d;
            cnt_q       <= cnt_d;
            jump_pend_q <= jump_pend_d;
            duck_pend_q <= duck_pend_d;
            land_duck_q <= land_duck_d;
            landed_q    <= landed_d;
        end
    end

    always_comb begin
        acc_sh = acc_q >> HEIGHT_SHIFT;
        if (|acc_sh[ACC_W-1:10]) begin
            height_out = 10'd1023;
        end else begin
            height_out = acc_sh[9:0];
        end
    end

    assign airborne_out = (state_q == StAir);
    assign ducking_out  = (state_q == StDuck);
    assign landed_out   = landed_q;

endmodule
